// File: rtl/t08_wb_sram_responder.sv
// Wishbone B4 classic responder backed by a word-addressed register array.
// Single read/write cycles, byte-lane writes, fixed wait states before ACK,
// one forced idle cycle after every ACK so a held strobe is not double-counted.

// One byte lane of the backing array; contents are intentionally not reset.
module t08_wb_sram_lane #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdat,
  output logic [7:0]    rdat
);
  logic [7:0] mem [DEPTH_WORDS];

  // byte write at the end of the ACK cycle
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdat;
  end

  assign rdat = mem[idx];
endmodule

module t08_wb_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH_WORDS);
  // decoded window size in bytes, one bit wider so it can never wrap
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_GAP} state_t;

  typedef struct packed {
    logic                 we;
    logic [NUM_LANES-1:0] sel;
    logic                 hit;
    logic [AW-1:0]        idx;
    logic [31:0]          dat;
  } req_t;

  state_t state, state_nxt;
  req_t   req;
  logic [2:0] wait_cnt;
  logic       capture;
  logic       mem_we;

  // address decode on the live bus; only consumed at capture time
  logic [31:0] offset;
  logic        adr_hit;
  assign offset  = wbs_adr_i - BASE_ADDR;
  assign adr_hit = (wbs_adr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);

  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] rd_lane;
  logic [31:0]               rd_word;
  assign rd_word = rd_lane;

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      // reset during the ACK cycle suppresses the write
      assign lane_we[l] = mem_we & req.sel[l] & ~wb_rst_i;
      t08_wb_sram_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
        .clk  (wb_clk_i),
        .we   (lane_we[l]),
        .idx  (req.idx),
        .wdat (req.dat[8*l +: 8]),
        .rdat (rd_lane[l])
      );
    end
  endgenerate

  // state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // request capture; the captured copy drives the whole cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)     req <= '0;
    else if (capture) req <= '{we: wbs_we_i, sel: wbs_sel_i, hit: adr_hit,
                               idx: offset[AW+1:2], dat: wbs_dat_i};
  end

  // wait-state counter: loaded at capture, counts down while waiting
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                                  wait_cnt <= 3'd0;
    else if (capture)                              wait_cnt <= CNT_LOAD;
    else if (state == ST_WAIT && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
  end

  // next state and bus outputs
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    mem_we    = 1'b0;
    wbs_ack_o = 1'b0;
    wbs_dat_o = 32'h0;
    case (state)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          capture   = 1'b1;
          state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // initiator abandoning the cycle wins over a wait that just expired
        if (!(wbs_cyc_i && wbs_stb_i)) state_nxt = ST_IDLE;
        else if (wait_cnt == 3'd0)     state_nxt = ST_ACK;
      end
      ST_ACK: begin
        wbs_ack_o = 1'b1;
        mem_we    = req.we && req.hit;
        if (!req.we && req.hit) wbs_dat_o = rd_word;
        state_nxt = ST_GAP;
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_t08_wb_sram_responder.sv
// Bench for t08_wb_sram_responder: three instances (1, 0 and 7 wait states)
// driven independently and checked against a word-array reference model.
module tb_t08_wb_sram_responder;
  localparam logic [31:0] BASE  = 32'h3300_0000;
  localparam int          DEPTH = 256;
  localparam int          ND    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        cyc  [ND];
  logic        stb  [ND];
  logic        we   [ND];
  logic [3:0]  sel  [ND];
  logic [31:0] adr  [ND];
  logic [31:0] dati [ND];
  logic [31:0] dato [ND];
  logic        ack  [ND];

  int          ws_of [ND];
  logic [31:0] mdl   [ND][DEPTH];
  bit          known [ND][DEPTH];
  int          n_asrt = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  t08_wb_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]),
    .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(dati[0]),
    .wbs_ack_o(ack[0]), .wbs_dat_o(dato[0]));
  t08_wb_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]),
    .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(dati[1]),
    .wbs_ack_o(ack[1]), .wbs_dat_o(dato[1]));
  t08_wb_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(7)) u2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]),
    .wbs_we_i(we[2]), .wbs_sel_i(sel[2]), .wbs_adr_i(adr[2]), .wbs_dat_i(dati[2]),
    .wbs_ack_o(ack[2]), .wbs_dat_o(dato[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [63:0] a64;
    a64 = {32'h0, a};
    return (a64 >= {32'h0, BASE}) && (a64 < {32'h0, BASE} + 64'(4 * DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // reference write: selected bytes of an in-range word change, nothing else
  function automatic void mdl_wr(input int d, input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] v);
    int i;
    if (!in_rng(a)) return;
    i = widx(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[d][i][8*b +: 8] = v[8*b +: 8];
    if (s == 4'hF) known[d][i] = 1'b1;
  endfunction

  task automatic idle_bus(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0;
    adr[d] = 32'h0; dati[d] = 32'h0;
  endtask

  // one classic cycle: latency, read data, and the quiet cycle after ACK
  task automatic xfer(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] wd, input string tag, output logic [31:0] rd);
    int lat;
    bit got;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dati[d] = wd;
    lat = 0; got = 1'b0; rd = 32'h0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack[d]) got = 1'b1;
      else begin
        chk({tag, " dat_o before ack"}, dato[d], 32'h0);
        // captured request must not follow the bus after capture
        we[d] = 1'($urandom); sel[d] = 4'($urandom);
        adr[d] = $urandom; dati[d] = $urandom;
      end
    end
    chk({tag, " ack seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " latency"}, 32'(lat), 32'(ws_of[d] + 1));
      rd = dato[d];
      if (!w) begin
        if (!in_rng(a))               chk({tag, " read oor"}, rd, 32'h0);
        else if (known[d][widx(a)])   chk({tag, " read data"}, rd, mdl[d][widx(a)]);
      end
    end
    if (w) mdl_wr(d, a, s, wd);
    idle_bus(d);
    @(negedge clk);
    chk({tag, " ack after"}, 32'(ack[d]), 32'd0);
    chk({tag, " dat after"}, dato[d], 32'h0);
  endtask

  // strobe held high across two reads (words 0 and 1)
  task automatic held_pair(input int d);
    int n, t1, t2;
    n = 0; t1 = 0; t2 = 0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; sel[d] = 4'hF; adr[d] = BASE;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (ack[d]) begin
        n++;
        if (n == 1) begin
          t1 = t;
          chk("held word0", dato[d], mdl[d][0]);
          adr[d] = BASE + 32'd4;
        end else if (n == 2) begin
          t2 = t;
          chk("held word1", dato[d], mdl[d][1]);
          idle_bus(d);
        end
      end
    end
    idle_bus(d);
    chk("held ack count", 32'(n), 32'd2);
    chk("held first latency", 32'(t1), 32'(ws_of[d] + 1));
    chk("held ack spacing", 32'(t2 - t1), 32'(ws_of[d] + 3));
  endtask

  // write abandoned mid-wait leaves no trace
  task automatic abort_wr(input int d, input int i, input logic [31:0] v);
    logic [31:0] rd;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; sel[d] = 4'hF;
    adr[d] = BASE + 32'(4 * i); dati[d] = v;
    repeat (ws_of[d]) @(negedge clk);
    idle_bus(d);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort no ack", 32'(ack[d]), 32'd0);
    end
    xfer(d, 1'b0, 4'hF, BASE + 32'(4 * i), 32'h0, "abort readback", rd);
  endtask

  initial begin
    logic [31:0] rd;
    ws_of[0] = 1; ws_of[1] = 0; ws_of[2] = 7;
    for (int d = 0; d < ND; d++) begin
      idle_bus(d);
      for (int i = 0; i < DEPTH; i++) begin mdl[d][i] = 32'h0; known[d][i] = 1'b0; end
    end

    // reset state
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        chk("reset ack", 32'(ack[d]), 32'd0);
        chk("reset dat", dato[d], 32'h0);
      end
    end
    rst = 1'b0;

    // basic write/read at word 2
    xfer(0, 1'b1, 4'hF, BASE + 32'd8, 32'hDEAD_BEEF, "wr beef", rd);
    xfer(0, 1'b0, 4'hF, BASE + 32'd8, 32'h0, "rd beef", rd);
    chk("beef value", rd, 32'hDEAD_BEEF);

    // byte lanes at word 4
    xfer(0, 1'b1, 4'hF,    BASE + 32'd16, 32'h1122_3344, "wr lanes a", rd);
    xfer(0, 1'b1, 4'b0101, BASE + 32'd16, 32'hAABB_CCDD, "wr lanes b", rd);
    xfer(0, 1'b1, 4'b0000, BASE + 32'd16, 32'h5555_5555, "wr lanes none", rd);
    xfer(0, 1'b0, 4'b0001, BASE + 32'd16, 32'h0, "rd lanes", rd);
    chk("lanes value", rd, 32'h11BB_33DD);

    // out of range on both sides, no aliasing onto first/last word
    xfer(0, 1'b1, 4'hF, BASE + 32'd4 * DEPTH - 32'd4, 32'hCAFE_0255, "wr last", rd);
    xfer(0, 1'b1, 4'hF, BASE, 32'hCAFE_0000, "wr first", rd);
    xfer(0, 1'b1, 4'hF, BASE + 32'd4 * DEPTH, 32'hFFFF_FFFF, "wr oor hi", rd);
    xfer(0, 1'b1, 4'hF, BASE - 32'd4, 32'hEEEE_EEEE, "wr oor lo", rd);
    xfer(0, 1'b0, 4'hF, BASE + 32'd4 * DEPTH, 32'h0, "rd oor hi", rd);
    chk("oor hi value", rd, 32'h0);
    xfer(0, 1'b0, 4'hF, BASE - 32'd4, 32'h0, "rd oor lo", rd);
    xfer(0, 1'b0, 4'hF, BASE + 32'd4 * DEPTH - 32'd4, 32'h0, "rd last", rd);
    chk("last value", rd, 32'hCAFE_0255);
    xfer(0, 1'b0, 4'hF, BASE, 32'h0, "rd first", rd);
    chk("first value", rd, 32'hCAFE_0000);

    // reset mid-wait drops the pending write
    xfer(0, 1'b1, 4'hF, BASE + 32'd20, 32'h0A0A_0A0A, "wr pre-reset", rd);
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    adr[0] = BASE + 32'd20; dati[0] = 32'hB0B0_B0B0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst wait ack", 32'(ack[0]), 32'd0);
      chk("rst wait dat", dato[0], 32'h0);
    end
    idle_bus(0);
    rst = 1'b0;
    xfer(0, 1'b0, 4'hF, BASE + 32'd20, 32'h0, "rd post-reset", rd);
    chk("post-reset value", rd, 32'h0A0A_0A0A);

    // reset coinciding with the ACK cycle drops the write (7 wait states)
    xfer(2, 1'b1, 4'hF, BASE + 32'd24, 32'h1357_9BDF, "wr pre-ackrst", rd);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
    adr[2] = BASE + 32'd24; dati[2] = 32'hFEDC_BA98;
    repeat (ws_of[2] + 1) @(negedge clk);
    chk("ackrst ack", 32'(ack[2]), 32'd1);
    idle_bus(2);
    rst = 1'b1;
    @(negedge clk);
    chk("ackrst ack drop", 32'(ack[2]), 32'd0);
    rst = 1'b0;
    xfer(2, 1'b0, 4'hF, BASE + 32'd24, 32'h0, "rd post-ackrst", rd);
    chk("post-ackrst value", rd, 32'h1357_9BDF);

    // aborted writes
    xfer(0, 1'b1, 4'hF, BASE + 32'd12, 32'h7777_0003, "wr pre-abort", rd);
    abort_wr(0, 3, 32'h9999_9999);
    xfer(2, 1'b1, 4'hF, BASE + 32'd12, 32'h7777_2003, "wr pre-abort2", rd);
    abort_wr(2, 3, 32'h9999_9999);

    // randomized traffic plus held-strobe pairs on every instance
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 16; i++)
        xfer(d, 1'b1, 4'hF, BASE + 32'(4 * i), $urandom, "prefill", rd);
      held_pair(d);
      for (int n = 0; n < 50; n++) begin
        int r;
        logic [31:0] a;
        logic [3:0]  s;
        r = int'($urandom_range(0, 9));
        if (r < 8)       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        else if (r == 8) a = BASE + 32'd4 * DEPTH + 32'(4 * $urandom_range(0, 3));
        else             a = BASE - 32'(4 * $urandom_range(1, 4));
        s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        xfer(d, 1'($urandom), s, a, $urandom, "random", rd);
      end
      held_pair(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
